// File: rtl/fetch_unit.sv
// fetch_unit: instruction prefetch unit with a small FIFO of {instr, pc} pairs.
// Issues one outstanding fetch at a time to instruction memory, queues returned
// words, and flushes and refetches on a redirect. A request that is already in
// flight when a redirect arrives cannot be withdrawn; its response is dropped.
//
// Ports
//   clk, reset        : clock, async active-low reset
//   imem_req/addr     : fetch request, held until imem_ack
//   imem_ack/data     : one-cycle response pulse with the fetched word
//   instr_valid/instr/instr_pc : queue head toward the consumer
//   instr_ready       : consumer pops the head this cycle
//   redirect/_addr    : flush queue and restart fetching at redirect_addr
//   count             : queue occupancy
module fetch_unit #(
  parameter int WORD_SIZE = 19,
  parameter int ADDR_SIZE = 19,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [ADDR_SIZE-1:0]     imem_addr,
  input  logic                     imem_ack,
  input  logic [WORD_SIZE-1:0]     imem_data,
  output logic                     instr_valid,
  output logic [WORD_SIZE-1:0]     instr,
  output logic [ADDR_SIZE-1:0]     instr_pc,
  input  logic                     instr_ready,
  input  logic                     redirect,
  input  logic [ADDR_SIZE-1:0]     redirect_addr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  typedef struct packed {
    logic [WORD_SIZE-1:0] instr;
    logic [ADDR_SIZE-1:0] pc;
  } entry_t;

  entry_t                 q_mem_q [DEPTH];
  logic [1:0]             state_q, state_d;
  logic [ADDR_SIZE-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_SIZE-1:0]   drop_addr_q, drop_addr_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   push, pop, space;
  entry_t                 head;

  assign instr_valid = (count_q != '0);
  assign count       = count_q;
  assign head        = q_mem_q[rd_ptr_q];
  // Gate the head so an empty queue presents zeros instead of stale entries.
  assign instr       = instr_valid ? head.instr : '0;
  assign instr_pc    = instr_valid ? head.pc    : '0;
  assign imem_req    = (state_q != S_IDLE);
  // While dropping, the in-flight address stays on the bus; fetch_pc already
  // holds the redirect target for the next request.
  assign imem_addr   = (state_q == S_DROP) ? drop_addr_q : fetch_pc_q;

  // Queue bookkeeping. A redirect wins over any push or pop in the same cycle.
  always_comb begin
    pop      = instr_valid & instr_ready & ~redirect;
    push     = (state_q == S_WAIT) & imem_ack & ~redirect;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    // Space is judged on post-edge occupancy so a full queue never takes a
    // request it could not store.
    space = (count_d < CW'(DEPTH));
  end

  // Fetch FSM.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    if (redirect) fetch_pc_d = redirect_addr;
    case (state_q)
      S_IDLE: begin
        // A stray imem_ack here is a protocol error and is ignored.
        if (space) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_ack) begin
          if (redirect) begin
            state_d = S_IDLE;
          end else begin
            fetch_pc_d = fetch_pc_q + ADDR_SIZE'(1);
            state_d    = space ? S_WAIT : S_IDLE;
          end
        end else if (redirect) begin
          state_d     = S_DROP;
          drop_addr_d = fetch_pc_q;
        end
      end
      S_DROP: begin
        if (imem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= '0;
      drop_addr_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) q_mem_q[i] <= '0;
    end else if (push) begin
      q_mem_q[wr_ptr_q] <= '{instr: imem_data, pc: fetch_pc_q};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. A behavioural memory
// (configurable / random ack latency, data = addr + 0x100) answers requests.
// Directed table vectors, hand-written corner sequences, then a randomized run
// compared each cycle against a transaction-level queue model.
module tb_fetch_unit;
  localparam int WS    = 19;
  localparam int AS    = 19;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int OVW   = 1 + AS + 1 + CW + WS + AS;

  typedef logic [OVW-1:0] ov_t;
  typedef struct packed { logic [WS-1:0] instr; logic [AS-1:0] pc; } ent_t;
  typedef struct {
    bit ready; bit redir; logic [AS-1:0] raddr;
    bit ereq; logic [AS-1:0] eaddr; logic [CW-1:0] ecnt; bit evld; logic [AS-1:0] epc;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic imem_req, imem_ack, instr_valid, instr_ready, redirect;
  logic [AS-1:0] imem_addr, instr_pc, redirect_addr;
  logic [WS-1:0] imem_data, instr;
  logic [CW-1:0] count;

  fetch_unit #(.WORD_SIZE(WS), .ADDR_SIZE(AS), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_addr(redirect_addr), .count(count)
  );

  int errors = 0;
  int checks = 0;

  // memory model controls
  int mlat, mcnt;
  bit rnd_lat, stale_en, force_ack, model_en;

  // reference model: queue plus the single outstanding request
  ent_t          mq[$];
  logic [AS-1:0] m_pc, m_oaddr;
  bit            m_out, m_disc;

  vec_t tbl[13];

  function automatic logic [WS-1:0] mdata(input logic [AS-1:0] a);
    return WS'(a) + WS'(32'h100);
  endfunction

  function automatic ov_t got_vec();
    return {imem_req, imem_addr, instr_valid, count, instr, instr_pc};
  endfunction

  function automatic ov_t pack_exp(input int rq, input int ad, input int vl,
                                   input int cn, input int in, input int pc);
    return {1'(rq), AS'(ad), 1'(vl), CW'(cn), WS'(in), AS'(pc)};
  endfunction

  function automatic vec_t mk(input bit r, input bit rd, input int ra, input bit rq,
                              input int ea, input int ec, input bit v, input int pc);
    vec_t t;
    t.ready = r; t.redir = rd; t.raddr = AS'(ra);
    t.ereq = rq; t.eaddr = AS'(ea); t.ecnt = CW'(ec); t.evld = v; t.epc = AS'(pc);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input ov_t exp);
    checks++;
    if (got_vec() !== exp) begin
      errors++;
      $display("FAIL %s: got req=%0d addr=%h vld=%0d cnt=%0d instr=%h pc=%h; expected {req,addr,vld,cnt,instr,pc}=%h",
               nm, imem_req, imem_addr, instr_valid, count, instr, instr_pc, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc = '0; m_oaddr = '0; m_out = 0; m_disc = 0;
  endtask

  // One edge of the reference: drop/accept the response, pop/push, then decide
  // whether a request is outstanding after the edge.
  task automatic model_update(input logic a, input logic [WS-1:0] d, input bit rdy,
                              input bit rd, input logic [AS-1:0] ra);
    bit popv, acc;
    ent_t e;
    popv = (mq.size() != 0) && rdy && !rd;
    acc  = m_out && a && !m_disc && !rd;
    if (rd) begin
      mq.delete();
      m_pc = ra;
    end else begin
      if (popv) void'(mq.pop_front());
      if (acc) begin
        e.instr = d; e.pc = m_oaddr;
        mq.push_back(e);
        m_pc = m_pc + AS'(1);
      end
    end
    if (!m_out) begin
      if (mq.size() < DEPTH) begin m_out = 1; m_oaddr = m_pc; m_disc = 0; end
    end else if (a) begin
      if (acc && mq.size() < DEPTH) m_oaddr = m_pc;
      else m_out = 0;
    end else if (rd) begin
      m_disc = 1;
    end
  endtask

  // Advance to the next falling edge, let memory respond, drive the consumer
  // and redirect inputs, then (optionally) check against and step the model.
  task automatic step(input bit rdy, input bit rd, input logic [AS-1:0] ra);
    logic a;
    logic [WS-1:0] d;
    ov_t exp;
    @(negedge clk);
    a = 1'b0; d = '0;
    if (force_ack || (stale_en && !imem_req && $urandom_range(0, 15) == 0)) begin
      a = 1'b1; d = WS'($urandom);
    end else if (imem_req) begin
      if (mcnt >= mlat) begin
        a = 1'b1; d = mdata(imem_addr); mcnt = 0;
        if (rnd_lat) mlat = int'($urandom_range(0, 3));
      end else mcnt++;
    end else mcnt = 0;
    imem_ack = a; imem_data = d; instr_ready = rdy; redirect = rd; redirect_addr = ra;
    #1;
    if (model_en) begin
      exp = {m_out, (m_out ? m_oaddr : m_pc), (mq.size() != 0), CW'(mq.size()),
             (mq.size() != 0 ? mq[0].instr : WS'(0)), (mq.size() != 0 ? mq[0].pc : AS'(0))};
      chk_vec("model", exp);
      model_update(a, d, rdy, rd, ra);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    imem_ack = 0; imem_data = '0; instr_ready = 0; redirect = 0; redirect_addr = '0;
    force_ack = 0; mcnt = 0;
    @(negedge clk); #1;
    chk_vec("reset_state", pack_exp(0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    reset = 1'b0;
    imem_ack = 0; imem_data = '0; instr_ready = 0; redirect = 0; redirect_addr = '0;
    mlat = 0; mcnt = 0; rnd_lat = 0; stale_en = 0; force_ack = 0; model_en = 0;
    model_reset();

    // Fill to DEPTH with ready low, one pop/refetch, then redirect near the top
    // of the address space with a zero-wait memory and ready high.
    tbl[0]  = mk(0, 0, 0,       0, 0,       0, 0, 0);
    tbl[1]  = mk(0, 0, 0,       1, 0,       0, 0, 0);
    tbl[2]  = mk(0, 0, 0,       1, 1,       1, 1, 0);
    tbl[3]  = mk(0, 0, 0,       1, 2,       2, 1, 0);
    tbl[4]  = mk(0, 0, 0,       1, 3,       3, 1, 0);
    tbl[5]  = mk(1, 0, 0,       0, 4,       4, 1, 0);
    tbl[6]  = mk(0, 0, 0,       1, 4,       3, 1, 1);
    tbl[7]  = mk(0, 0, 0,       0, 5,       4, 1, 1);
    tbl[8]  = mk(1, 1, 'h7FFFE, 0, 5,       4, 1, 1);
    tbl[9]  = mk(1, 0, 0,       1, 'h7FFFE, 0, 0, 0);
    tbl[10] = mk(1, 0, 0,       1, 'h7FFFF, 1, 1, 'h7FFFE);
    tbl[11] = mk(1, 0, 0,       1, 0,       1, 1, 'h7FFFF);
    tbl[12] = mk(1, 0, 0,       1, 1,       1, 1, 0);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].ready, tbl[i].redir, tbl[i].raddr);
      chk_vec($sformatf("table_row%0d", i),
              {tbl[i].ereq, tbl[i].eaddr, tbl[i].evld, tbl[i].ecnt,
               (tbl[i].evld ? mdata(tbl[i].epc) : WS'(0)), tbl[i].epc});
    end

    // Redirect during the second wait cycle of a 3-cycle-latency fetch.
    mlat = 3;
    do_reset();
    step(1, 0, '0);
    chk("lat_idle_req", 64'(imem_req), 64'(0));
    step(1, 0, '0);
    chk_vec("lat_first_req", pack_exp(1, 0, 0, 0, 0, 0));
    step(1, 1, AS'(32'h40));
    step(1, 0, '0);
    chk_vec("drop_addr_hold", pack_exp(1, 0, 0, 0, 0, 0));
    step(1, 0, '0);
    chk("drop_ack_addr", 64'(imem_addr), 64'(0));
    step(1, 0, '0);
    chk_vec("drop_to_idle", pack_exp(0, 'h40, 0, 0, 0, 0));
    step(1, 0, '0);
    chk_vec("refetch_addr", pack_exp(1, 'h40, 0, 0, 0, 0));
    begin
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        step(1, 0, '0);
        if (instr_valid) seen = 1;
      end
      chk("redir_valid_seen", 64'(seen), 64'(1));
      chk("redir_first_pc", 64'(instr_pc), 64'(32'h40));
      chk("redir_first_instr", 64'(instr), 64'(32'h140));
    end

    // Redirect coincident with an accepted ack and a pop, count=2.
    mlat = 0;
    do_reset();
    step(0, 0, '0);
    step(0, 0, '0);
    step(0, 0, '0);
    step(1, 1, AS'(32'h10));
    chk("coinc_pre_count", 64'(count), 64'(2));
    chk("coinc_ack_live", 64'(imem_ack & imem_req), 64'(1));
    step(0, 0, '0);
    chk_vec("coinc_flushed", pack_exp(0, 'h10, 0, 0, 0, 0));
    step(0, 0, '0);
    chk_vec("coinc_refetch", pack_exp(1, 'h10, 0, 0, 0, 0));

    // Reset asserted mid-request with count=3, then a stale ack in IDLE.
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, '0);
    chk_vec("pre_rst_wait3", pack_exp(1, 3, 1, 3, 'h100, 0));
    #2 reset = 1'b0;
    #1;
    chk_vec("async_rst_mid_wait", pack_exp(0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    reset = 1'b1;
    mcnt = 0;
    force_ack = 1;
    step(0, 0, '0);
    chk_vec("stale_ack_idle", pack_exp(0, 0, 0, 0, 0, 0));
    force_ack = 0;
    step(0, 0, '0);
    chk_vec("first_fetch_after_rst", pack_exp(1, 0, 0, 0, 0, 0));

    // Randomized run against the reference model.
    do_reset();
    rnd_lat = 1; stale_en = 1; model_en = 1; mlat = int'($urandom_range(0, 3));
    for (int i = 0; i < 3000; i++) begin
      bit rdy, rd;
      logic [AS-1:0] ra;
      rdy = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 39) == 0);
      ra  = ($urandom_range(0, 3) == 0) ? AS'(32'h7FFFC + $urandom_range(0, 3)) : AS'($urandom);
      step(rdy, rd, ra);
    end
    model_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
